// File: rtl/ad7276_emu.sv
// AD7276 ADC-pair responder: shifts two streamed samples out on the
// master's cs/sclk pins using the same frame format the reader expects.
module ad7276_emu #(
   parameter int DATA_WIDTH  = 12,
   parameter int LEAD_ZEROS  = 2,
   parameter int FRAME_BITS  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  fpga_clk_i,
   input  logic                  reset_i,
   input  logic                  s_valid_i,
   output logic                  s_ready_o,
   input  logic [DATA_WIDTH-1:0] s_data_0_i,
   input  logic [DATA_WIDTH-1:0] s_data_1_i,
   input  logic                  cs_i,
   input  logic                  sclk_i,
   output logic                  data_0_o,
   output logic                  data_1_o,
   output logic                  data_oe_o,
   output logic                  frame_done_o,
   output logic                  abort_o,
   output logic                  underrun_o
);

   localparam int TRAIL = FRAME_BITS - LEAD_ZEROS - DATA_WIDTH;
   localparam int CW    = $clog2(FRAME_BITS + 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   logic [SYNC_STAGES-1:0] cs_sync;
   logic [SYNC_STAGES-1:0] sclk_sync;
   logic                   cs_q;
   logic                   sclk_q;
   logic                   cs_s;
   logic                   sclk_s;
   logic                   cs_fall;
   logic                   cs_rise;
   logic                   sclk_fall;

   logic [DATA_WIDTH-1:0]  hold_0;
   logic [DATA_WIDTH-1:0]  hold_1;
   logic                   full;
   logic                   load;
   logic                   capture;

   state_t                 state;
   logic [FRAME_BITS-1:0]  sr_0;
   logic [FRAME_BITS-1:0]  sr_1;
   logic [FRAME_BITS-1:0]  img_0;
   logic [FRAME_BITS-1:0]  img_1;
   logic [CW-1:0]          cnt;
   logic                   oe;
   logic                   done_p;
   logic                   abort_p;
   logic                   under_p;

   // CS chain resets low so a CS held low across reset never looks like a
   // fresh falling edge; only a new high-to-low transition starts a frame.
   always_ff @(posedge fpga_clk_i) begin
      if (reset_i) begin
         cs_sync   <= '0;
         cs_q      <= 1'b0;
         sclk_sync <= '1;
         sclk_q    <= 1'b1;
      end else begin
         cs_sync   <= (cs_sync << 1) | SYNC_STAGES'(cs_i);
         cs_q      <= cs_s;
         sclk_sync <= (sclk_sync << 1) | SYNC_STAGES'(sclk_i);
         sclk_q    <= sclk_s;
      end
   end

   assign cs_s      = cs_sync[SYNC_STAGES-1];
   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign cs_fall   = cs_q & ~cs_s;
   assign cs_rise   = ~cs_q & cs_s;
   assign sclk_fall = sclk_q & ~sclk_s;

   assign s_ready_o = ~full;
   assign load      = s_valid_i & s_ready_o;
   assign capture   = (state == IDLE) & cs_fall;

   always_ff @(posedge fpga_clk_i) begin
      if (reset_i) begin
         hold_0 <= '0;
         hold_1 <= '0;
         full   <= 1'b0;
      end else if (load) begin
         hold_0 <= s_data_0_i;
         hold_1 <= s_data_1_i;
         full   <= 1'b1;
      end else if (capture) begin
         full   <= 1'b0;
      end
   end

   assign img_0 = FRAME_BITS'(hold_0) << TRAIL;
   assign img_1 = FRAME_BITS'(hold_1) << TRAIL;

   always_ff @(posedge fpga_clk_i) begin
      if (reset_i) begin
         state   <= IDLE;
         sr_0    <= '0;
         sr_1    <= '0;
         cnt     <= '0;
         oe      <= 1'b0;
         done_p  <= 1'b0;
         abort_p <= 1'b0;
         under_p <= 1'b0;
      end else begin
         done_p  <= 1'b0;
         abort_p <= 1'b0;
         under_p <= 1'b0;
         unique case (state)
            IDLE: begin
               if (cs_fall) begin
                  sr_0    <= img_0;
                  sr_1    <= img_1;
                  cnt     <= CW'(FRAME_BITS);
                  oe      <= 1'b1;
                  under_p <= ~full;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               if (cs_rise) begin
                  abort_p <= 1'b1;
                  oe      <= 1'b0;
                  sr_0    <= '0;
                  sr_1    <= '0;
                  state   <= IDLE;
               end else if (sclk_fall) begin
                  sr_0 <= sr_0 << 1;
                  sr_1 <= sr_1 << 1;
                  cnt  <= cnt - CW'(1);
                  if (cnt == CW'(1)) begin
                     done_p <= 1'b1;
                     state  <= DONE;
                  end
               end
            end
            DONE: begin
               if (cs_rise) begin
                  oe    <= 1'b0;
                  sr_0  <= '0;
                  sr_1  <= '0;
                  state <= IDLE;
               end else if (sclk_fall) begin
                  sr_0 <= sr_0 << 1;
                  sr_1 <= sr_1 << 1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign data_0_o     = sr_0[FRAME_BITS-1];
   assign data_1_o     = sr_1[FRAME_BITS-1];
   assign data_oe_o    = oe;
   assign frame_done_o = done_p;
   assign abort_o      = abort_p;
   assign underrun_o   = under_p;

endmodule

// File: tb/tb_ad7276_emu.sv
// Randomised bench for ad7276_emu: a pin-level master plus a
// transaction-level model of the holding register and frame contents.
module tb_ad7276_emu;

   localparam int DW = 12;
   localparam int LZ = 2;
   localparam int FB = 16;
   localparam int SS = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [DW-1:0] d0 = '0;
   logic [DW-1:0] d1 = '0;
   logic          cs = 1'b1;
   logic          sclk = 1'b1;
   logic          q0, q1, oe, done, abrt, under;

   ad7276_emu #(
      .DATA_WIDTH(DW), .LEAD_ZEROS(LZ), .FRAME_BITS(FB), .SYNC_STAGES(SS)
   ) dut (
      .fpga_clk_i(clk), .reset_i(rst),
      .s_valid_i(s_valid), .s_ready_o(s_ready),
      .s_data_0_i(d0), .s_data_1_i(d1),
      .cs_i(cs), .sclk_i(sclk),
      .data_0_o(q0), .data_1_o(q1), .data_oe_o(oe),
      .frame_done_o(done), .abort_o(abrt), .underrun_o(under)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int nd, na, nu, cs_hi;
   logic pd, pa, pu;

   logic [DW-1:0] m_h0, m_h1;
   bit            m_full;
   logic [FB-1:0] rd0, rd1;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle monitor: idle pins, single-cycle pulses, pulse counts.
   always @(negedge clk) begin
      if (rst) begin
         cs_hi = 0;
         pd = 1'b0; pa = 1'b0; pu = 1'b0;
      end else begin
         cs_hi = cs ? cs_hi + 1 : 0;
         if (cs_hi >= SS + 4)
            check("idle_pins", 32'({oe, q0, q1}), 32'd0);
         if (done) begin nd++; check("done_width", 32'(pd), 32'd0); end
         if (abrt) begin na++; check("abort_width", 32'(pa), 32'd0); end
         if (under) begin nu++; check("under_width", 32'(pu), 32'd0); end
         pd = done; pa = abrt; pu = under;
      end
   end

   function automatic logic [FB-1:0] image(input logic [DW-1:0] s);
      return FB'(s) << (FB - LZ - DW);
   endfunction

   task automatic clock_bits(input int n, input logic [FB-1:0] w0,
                             input logic [FB-1:0] w1);
      logic e0, e1;
      for (int k = 0; k < n; k++) begin
         repeat (2) @(negedge clk);
         e0 = (k < FB) ? w0[FB-1-k] : 1'b0;
         e1 = (k < FB) ? w1[FB-1-k] : 1'b0;
         check("bit", 32'({oe, q0, q1}), 32'({1'b1, e0, e1}));
         if (k < FB) begin
            rd0 = {rd0[FB-2:0], q0};
            rd1 = {rd1[FB-2:0], q1};
         end
         sclk = 1'b0;
         repeat (2) @(negedge clk);
         sclk = 1'b1;
      end
   endtask

   task automatic load(input logic [DW-1:0] a, input logic [DW-1:0] b);
      @(negedge clk);
      check("ready_pre_load", 32'(s_ready), 32'(!m_full));
      s_valid = 1'b1; d0 = a; d1 = b;
      @(negedge clk);
      s_valid = 1'b0;
      if (!m_full) begin
         m_h0 = a; m_h1 = b; m_full = 1'b1;
      end
   endtask

   task automatic frame(input int n, input bit coload,
                        input logic [DW-1:0] c0, input logic [DW-1:0] c1);
      logic [FB-1:0] w0, w1;
      bit eu;
      w0 = image(m_h0);
      w1 = image(m_h1);
      eu = !m_full;
      if (coload && !m_full) begin
         m_h0 = c0; m_h1 = c1; m_full = 1'b1;
      end else begin
         m_full = 1'b0;
      end
      @(negedge clk);
      nd = 0; na = 0; nu = 0; rd0 = '0; rd1 = '0;
      cs = 1'b0;
      if (coload) begin
         @(posedge clk);
         @(posedge clk);
         @(negedge clk);
         s_valid = 1'b1; d0 = c0; d1 = c1;
         @(negedge clk);
         s_valid = 1'b0;
         repeat (4) @(negedge clk);
      end else begin
         repeat (6) @(negedge clk);
      end
      clock_bits(n, w0, w1);
      repeat (2) @(negedge clk);
      cs = 1'b1;
      repeat (SS + 2) @(negedge clk);
      check("oe_release", 32'(oe), 32'd0);
      repeat (6) @(negedge clk);
      check("frame_done_cnt", 32'(nd), 32'(n >= FB));
      check("abort_cnt", 32'(na), 32'(n < FB));
      check("underrun_cnt", 32'(nu), 32'(eu));
      check("ready_post", 32'(s_ready), 32'(!m_full));
   endtask

   task automatic reset_mid();
      logic [FB-1:0] w0, w1;
      bit eu;
      w0 = image(m_h0);
      w1 = image(m_h1);
      eu = !m_full;
      @(negedge clk);
      nd = 0; na = 0; nu = 0; rd0 = '0; rd1 = '0;
      cs = 1'b0;
      repeat (6) @(negedge clk);
      clock_bits(9, w0, w1);
      rst = 1'b1;
      @(negedge clk);
      check("mid_reset_state", 32'({s_ready, oe, q0, q1, done, abrt, under}),
            32'b1000000);
      rst = 1'b0;
      m_h0 = '0; m_h1 = '0; m_full = 1'b0;
      repeat (4) @(negedge clk);
      cs = 1'b1;
      repeat (10) @(negedge clk);
      check("mid_reset_done", 32'(nd), 32'd0);
      check("mid_reset_abort", 32'(na), 32'd0);
      check("mid_reset_under", 32'(nu), 32'(eu));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, r;
      m_h0 = '0; m_h1 = '0; m_full = 1'b0;
      repeat (4) @(negedge clk);
      check("reset_state", 32'({s_ready, oe, q0, q1, done, abrt, under}),
            32'b1000000);
      rst = 1'b0;
      repeat (8) @(negedge clk);

      load(12'hABC, 12'h123);
      frame(16, 1'b0, '0, '0);
      check("rd0_abc", 32'(rd0), 32'h2AF0);
      check("rd1_123", 32'(rd1), 32'h048C);

      frame(16, 1'b0, '0, '0);
      check("rd0_resend", 32'(rd0), 32'h2AF0);
      check("rd1_resend", 32'(rd1), 32'h048C);

      load(12'h111, 12'h222);
      frame(7, 1'b0, '0, '0);

      frame(16, 1'b1, 12'hFFF, 12'h000);
      check("rd0_old_pair", 32'(rd0), 32'h0444);
      frame(16, 1'b0, '0, '0);
      check("rd0_fff", 32'(rd0), 32'h3FFC);
      check("rd1_000", 32'(rd1), 32'h0000);

      load(12'h5A5, 12'hA5A);
      frame(20, 1'b0, '0, '0);
      check("rd1_a5a", 32'(rd1), 32'h2968);

      load(12'h321, 12'h654);
      reset_mid();
      frame(16, 1'b0, '0, '0);
      check("rd0_after_rst", 32'(rd0), 32'h0000);

      for (int i = 0; i < 25; i++) begin
         if ($urandom_range(0, 9) < 7)
            load(12'($urandom), 12'($urandom));
         r = int'($urandom_range(0, 4));
         if (r == 0) n = int'($urandom_range(1, 15));
         else if (r == 1) n = int'($urandom_range(17, 20));
         else n = FB;
         frame(n, ($urandom_range(0, 5) == 0), 12'($urandom), 12'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
